// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch write controller.
package sr_drv_pkg;

    // Controller phases, in the order a write walks through them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Width of the phase down-counter; covers the largest legal phase length.
    localparam int CNT_W = 8;

    // Drive pulse must last at least one cycle and fit the counter.
    function automatic bit pulse_cycles_legal(input int p);
        return (p >= 1) && (p <= 255);
    endfunction

    // Settle window must cover the two synchroniser flops and fit the counter.
    function automatic bit settle_cycles_legal(input int s);
        return (s >= 2) && (s <= 255);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous rail; clears to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw rail through two flops so q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_writer.sv
// Writes one value into an external NOR SR latch: a timed set or reset pulse,
// a quiet settle window, then a readback of both rails through synchronisers.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is high only while the controller is idle,
// req_value is captured on that edge, and req_valid is ignored while busy.
module sr_latch_writer
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_value,
    output logic       set_o,
    output logic       reset_o,
    input  logic       q_i,
    input  logic       qn_i,
    output logic       done,
    output logic       result_ok,
    output logic       state_valid,
    output logic       latched_value,
    output logic [1:0] dbg_state
);

    // Reject out-of-range phase lengths while elaborating.
    if (!pulse_cycles_legal(PULSE_CYCLES)) begin : g_bad_pulse
        $fatal(1, "sr_latch_writer: PULSE_CYCLES must be 1..255");
    end
    if (!settle_cycles_legal(SETTLE_CYCLES)) begin : g_bad_settle
        $fatal(1, "sr_latch_writer: SETTLE_CYCLES must be 2..255");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             val, val_nx;
    logic             set_nx, reset_nx;
    logic             accept;
    logic             q_s, qn_s;
    logic             rails_ok;

    sync2 u_sync_q  (.clk(clk), .rst_n(rst_n), .d(q_i),  .q(q_s));
    sync2 u_sync_qn (.clk(clk), .rst_n(rst_n), .d(qn_i), .q(qn_s));

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign done      = (state == CHECK);
    assign dbg_state = state;

    // Equal rails (both low or both high) never count as a valid latch state.
    assign rails_ok  = (q_s != qn_s) && (q_s == val);
    assign result_ok = done && rails_ok;

    // Next phase, counter and captured value; drives are derived from the next
    // phase so they are registered and can never be high together.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        val_nx   = val;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LOAD;
                    val_nx   = req_value;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nx = SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            CHECK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        set_nx   = (state_nx == PULSE) &&  val_nx;
        reset_nx = (state_nx == PULSE) && !val_nx;
    end

    // Phase state, counter and latch drives; reset drops the drives immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            val     <= 1'b0;
            set_o   <= 1'b0;
            reset_o <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            val     <= val_nx;
            set_o   <= set_nx;
            reset_o <= reset_nx;
        end
    end

    // Record the verified latch content after each readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_valid   <= 1'b0;
            latched_value <= 1'b0;
        end else if (state == CHECK) begin
            state_valid <= rails_ok;
            if (rails_ok) begin
                latched_value <= val;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Bench for sr_latch_writer: a default-parameter instance driving a NOR latch
// model, plus a short-timing instance whose rails are tied to a set latch.
module tb_sr_latch_writer;
    import sr_drv_pkg::*;

    localparam int P   = 4;
    localparam int S   = 10;
    localparam int LAT = P + S + 1;
    localparam int W   = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default-parameter instance signals
    logic       req_valid = 1'b0;
    logic       req_value = 1'b0;
    logic       req_ready, set_o, reset_o, q_i, qn_i;
    logic       done, result_ok, state_valid, latched_value;
    logic [1:0] dbg_state;

    // Short-timing instance signals
    logic       b_req_valid = 1'b0;
    logic       b_req_value = 1'b0;
    logic       b_q_i = 1'b1;
    logic       b_qn_i = 1'b0;
    logic       b_req_ready, b_set_o, b_reset_o;
    logic       b_done, b_result_ok, b_state_valid, b_latched_value;
    logic [1:0] b_dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;

    // Scoreboard: {result_ok, latched_value, state_valid, done cycle[15:0]}
    logic [W-1:0] exp_q[$];
    logic         model_lv = 1'b0;
    logic         model_sv = 1'b0;
    logic         pend = 1'b0;
    logic         pend_lv = 1'b0;
    logic         pend_sv = 1'b0;

    always #5 clk = ~clk;

    sr_latch_writer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_value(req_value), .set_o(set_o), .reset_o(reset_o), .q_i(q_i),
        .qn_i(qn_i), .done(done), .result_ok(result_ok), .state_valid(state_valid),
        .latched_value(latched_value), .dbg_state(dbg_state)
    );

    sr_latch_writer #(.PULSE_CYCLES(1), .SETTLE_CYCLES(2)) u_dut_short (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_value(b_req_value), .set_o(b_set_o), .reset_o(b_reset_o), .q_i(b_q_i),
        .qn_i(b_qn_i), .done(b_done), .result_ok(b_result_ok),
        .state_valid(b_state_valid), .latched_value(b_latched_value),
        .dbg_state(b_dbg_state)
    );

    // NOR latch model with a two-cycle gate delay; rails read 0/0 until the
    // first write and can be forced to a stuck Q=0 state.
    logic stuck = 1'b0;
    logic core = 1'b0;
    logic known = 1'b0;
    logic d1 = 1'b0;
    logic d1k = 1'b0;

    always @(posedge clk) begin
        if (set_o && !reset_o) begin
            core  <= 1'b1;
            known <= 1'b1;
        end else if (reset_o && !set_o) begin
            core  <= 1'b0;
            known <= 1'b1;
        end
        d1  <= core;
        d1k <= known;
    end

    assign q_i  = stuck ? 1'b0 : (d1k ?  d1 : 1'b0);
    assign qn_i = stuck ? 1'b1 : (d1k ? ~d1 : 1'b0);

    // Per-cycle output checks and scoreboard pops, run at the falling edge.
    task automatic monitor();
        logic [W-1:0] e;
        total++;
        if (set_o && reset_o) begin
            bad++;
            $display("FAIL overlap: set_o=%0b reset_o=%0b required not both 1 (cyc %0d)", set_o, reset_o, cyc);
        end
        total++;
        if (b_set_o && b_reset_o) begin
            bad++;
            $display("FAIL overlap_short: set_o=%0b reset_o=%0b required not both 1", b_set_o, b_reset_o);
        end
        if (pend) begin
            pend = 1'b0;
            total++;
            if (latched_value !== pend_lv || state_valid !== pend_sv) begin
                bad++;
                $display("FAIL post_check_state: lv=%0b sv=%0b required lv=%0b sv=%0b", latched_value, state_valid, pend_lv, pend_sv);
            end
        end
        if (done === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done=1 at cyc %0d required no done", cyc);
            end else begin
                e = exp_q.pop_front();
                if (result_ok !== e[18]) begin
                    bad++;
                    $display("FAIL result_ok: got %0b required %0b (cyc %0d)", result_ok, e[18], cyc);
                end
                total++;
                if (16'(cyc) !== e[15:0]) begin
                    bad++;
                    $display("FAIL done_latency: done at cyc %0d required cyc %0d", cyc, e[15:0]);
                end
                pend    = 1'b1;
                pend_lv = e[17];
                pend_sv = e[16];
            end
        end
    endtask

    // Advance one cycle; records an accept on the coming edge in the scoreboard.
    task automatic tick();
        logic ok, lv;
        if (rst_n && req_valid && req_ready) begin
            ok = stuck ? !req_value : 1'b1;
            lv = ok ? req_value : model_lv;
            exp_q.push_back({ok, lv, ok, 16'(cyc + LAT)});
            model_lv = lv;
            model_sv = ok;
            last_acc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend || !req_ready) && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || pend || !req_ready) begin
            bad++;
            $display("FAIL wait_idle: pending=%0d after %0d cycles required 0", exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (req_ready !== 1'b1 || set_o !== 1'b0 || reset_o !== 1'b0 || done !== 1'b0 ||
            state_valid !== 1'b0 || latched_value !== 1'b0 || result_ok !== 1'b0 || dbg_state !== IDLE) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%0b s=%0b r=%0b done=%0b sv=%0b lv=%0b ok=%0b st=%0d required 1,0,0,0,0,0,0,0",
                     req_ready, set_o, reset_o, done, state_valid, latched_value, result_ok, dbg_state);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (req_ready !== 1'b1 || set_o !== 1'b0 || reset_o !== 1'b0 || done !== 1'b0 || state_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_outputs: rdy=%0b s=%0b r=%0b done=%0b sv=%0b required 1,0,0,0,0",
                         req_ready, set_o, reset_o, done, state_valid);
            end
        end
    endtask

    task automatic test_set();
        req_valid = 1'b1;
        req_value = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int n = 1; n <= LAT; n++) begin
            total++;
            if (set_o !== (n <= P) || reset_o !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL set_pulse: t%0d s=%0b r=%0b rdy=%0b required s=%0b r=0 rdy=0",
                         n, set_o, reset_o, req_ready, (n <= P));
            end
            total++;
            if (done !== (n == LAT) || (n == LAT && result_ok !== 1'b1)) begin
                bad++;
                $display("FAIL set_done: t%0d done=%0b ok=%0b required done=%0b ok=1 at t%0d",
                         n, done, result_ok, (n == LAT), LAT);
            end
            tick();
        end
        total++;
        if (req_ready !== 1'b1 || latched_value !== 1'b1 || state_valid !== 1'b1) begin
            bad++;
            $display("FAIL set_after: rdy=%0b lv=%0b sv=%0b required 1,1,1", req_ready, latched_value, state_valid);
        end
        wait_idle(50);
    endtask

    task automatic test_back_to_back();
        int first_acc, n_set, n_rst, last_rst, first_set, accepts;
        n_set = 0; n_rst = 0; last_rst = -1; first_set = -1; accepts = 0; first_acc = 0;
        req_valid = 1'b1;
        req_value = 1'b0;
        for (int n = 0; n < 3 * LAT && accepts < 2; n++) begin
            if (req_ready) begin
                accepts++;
            end
            tick();
            if (accepts == 1 && req_value == 1'b0) begin
                first_acc = last_acc;
                req_value = 1'b1;
            end
            if (reset_o) begin
                n_rst++;
                last_rst = cyc;
            end
            if (set_o) begin
                n_set++;
                if (first_set < 0) first_set = cyc;
            end
        end
        req_valid = 1'b0;
        for (int n = 0; n < LAT + 2; n++) begin
            tick();
            if (reset_o) n_rst++;
            if (set_o) n_set++;
        end
        total++;
        if (accepts != 2 || last_acc - first_acc != LAT + 1) begin
            bad++;
            $display("FAIL b2b_accept: accepts=%0d spacing=%0d required 2 and %0d", accepts, last_acc - first_acc, LAT + 1);
        end
        total++;
        if (n_rst != P || n_set != P || first_set - last_rst < 2) begin
            bad++;
            $display("FAIL b2b_pulses: rst=%0d set=%0d gap=%0d required %0d,%0d,>=2", n_rst, n_set, first_set - last_rst, P, P);
        end
        wait_idle(50);
        total++;
        if (latched_value !== 1'b1 || state_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_state: lv=%0b sv=%0b required 1,1", latched_value, state_valid);
        end
    endtask

    task automatic test_stuck();
        req_valid = 1'b1;
        req_value = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_idle(50);
        stuck = 1'b1;
        req_valid = 1'b1;
        req_value = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_idle(50);
        total++;
        if (state_valid !== 1'b0 || latched_value !== 1'b0) begin
            bad++;
            $display("FAIL stuck_state: sv=%0b lv=%0b required sv=0 lv=0", state_valid, latched_value);
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        req_valid = 1'b1;
        req_value = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        total++;
        if (set_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_pulse_drive: set_o=%0b at t2 required 1", set_o);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (set_o !== 1'b0 || reset_o !== 1'b0 || req_ready !== 1'b1 || state_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_drop: s=%0b r=%0b rdy=%0b sv=%0b required 0,0,1,0", set_o, reset_o, req_ready, state_valid);
        end
        exp_q.delete();
        pend = 1'b0;
        model_lv = 1'b0;
        model_sv = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || req_ready !== 1'b1 || state_valid !== 1'b0) begin
                bad++;
                $display("FAIL after_reset: done=%0b rdy=%0b sv=%0b required 0,1,0", done, req_ready, state_valid);
            end
        end
    endtask

    task automatic test_short_timing();
        logic exp_done, exp_set, exp_rdy;
        b_req_valid = 1'b1;
        b_req_value = 1'b1;
        total++;
        if (b_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL short_ready_t0: rdy=%0b required 1", b_req_ready);
        end
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_done = (n == 4) || (n == 9);
            exp_set  = (n == 1) || (n == 6);
            exp_rdy  = (n == 5) || (n >= 10);
            total++;
            if (b_done !== exp_done || b_set_o !== exp_set || b_req_ready !== exp_rdy || b_reset_o !== 1'b0) begin
                bad++;
                $display("FAIL short_timing: t%0d done=%0b s=%0b rdy=%0b r=%0b required %0b,%0b,%0b,0",
                         n, b_done, b_set_o, b_req_ready, b_reset_o, exp_done, exp_set, exp_rdy);
            end
            if (exp_done) begin
                total++;
                if (b_result_ok !== 1'b1 || b_dbg_state !== CHECK) begin
                    bad++;
                    $display("FAIL short_result: t%0d ok=%0b st=%0d required ok=1 st=%0d", n, b_result_ok, b_dbg_state, CHECK);
                end
            end
            if (n == 5) begin
                total++;
                if (b_state_valid !== 1'b1 || b_latched_value !== 1'b1) begin
                    bad++;
                    $display("FAIL short_state: sv=%0b lv=%0b required 1,1", b_state_valid, b_latched_value);
                end
            end
            if (n == 9) b_req_valid = 1'b0;
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        @(negedge clk);
        test_reset();
        test_set();
        test_back_to_back();
        test_stuck();
        test_reset_mid_pulse();
        test_short_timing();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected writes never completed, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
